// File: rtl/mult_pkg.sv
// Shared definitions for the multiply dispatcher and its sequential multiplier:
// default operand width, wait timeout and the dispatcher state encoding.
package mult_pkg;

   localparam int MULT_WIDTH   = 8;
   localparam int MULT_TIMEOUT = 15;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/op_fifo.sv
// In-order operand FIFO. DEPTH must be a power of two (>= 2); pointers carry an
// extra wrap bit so full and empty are distinguished without a separate counter.
module op_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Full depends only on the pointers, never on a same-cycle pop.
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign dout      = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mult_dispatch.sv
// Feeds buffered operand pairs to an external sequential multiplier one at a
// time and returns full-width products in order over a valid/ready stream.
module mult_dispatch
   import mult_pkg::*;
#(
   parameter int WIDTH   = MULT_WIDTH,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = MULT_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               mul_start,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic [2*WIDTH-1:0] mul_product,
   input  logic               mul_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic               busy,
   output logic               timeout_err,
   output logic [7:0]         done_count
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; in_ready is FIFO-not-full, out_valid holds until out_ready.
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t               r_state;
   logic [CW-1:0]        r_wait_cnt;
   logic                 r_mul_start;
   logic [WIDTH-1:0]     r_mul_a;
   logic [WIDTH-1:0]     r_mul_b;
   logic                 r_out_valid;
   logic [2*WIDTH-1:0]   r_out_product;
   logic                 r_timeout_err;
   logic [7:0]           r_done_count;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic [2*WIDTH-1:0]   w_fifo_din;
   logic [2*WIDTH-1:0]   w_fifo_dout;

   assign w_fifo_din = {in_a, in_b};
   assign w_pop      = (r_state == S_IDLE) && !w_empty;

   op_fifo #(
      .WIDTH (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_op_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid),
      .pop   (w_pop),
      .full  (w_full),
      .empty (w_empty),
      .din   (w_fifo_din),
      .dout  (w_fifo_dout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_wait_cnt    <= '0;
         r_mul_start   <= 1'b0;
         r_mul_a       <= '0;
         r_mul_b       <= '0;
         r_out_valid   <= 1'b0;
         r_out_product <= '0;
         r_timeout_err <= 1'b0;
         r_done_count  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_mul_a     <= w_fifo_dout[2*WIDTH-1:WIDTH];
                  r_mul_b     <= w_fifo_dout[WIDTH-1:0];
                  r_mul_start <= 1'b1;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_mul_start <= 1'b0;
               r_wait_cnt  <= CW'(1);
               r_state     <= S_WAIT;
            end
            S_WAIT: begin
               // r_wait_cnt is the 1-based index of the current WAIT cycle;
               // mul_ready in the first one may be stale from the last op.
               if (mul_ready && (r_wait_cnt != CW'(1))) begin
                  r_out_product <= mul_product;
                  r_out_valid   <= 1'b1;
                  r_state       <= S_HOLD;
               end else if (r_wait_cnt == CW'(TIMEOUT)) begin
                  r_timeout_err <= 1'b1;
                  r_state       <= S_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_out_valid  <= 1'b0;
                  r_done_count <= r_done_count + 8'd1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = !w_full;
   assign mul_start   = r_mul_start;
   assign mul_a       = r_mul_a;
   assign mul_b       = r_mul_b;
   assign out_valid   = r_out_valid;
   assign out_product = r_out_product;
   assign timeout_err = r_timeout_err;
   assign done_count  = r_done_count;
   assign busy        = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_mult_dispatch.sv
// Directed bench for mult_dispatch with a behavioural sequential multiplier
// that can be switched into a never-ready stub.
module tb_mult_dispatch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        mul_start;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_product;
   logic        mul_ready;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_product;
   logic        busy;
   logic        timeout_err;
   logic [7:0]  done_count;

   int total = 0;
   int bad   = 0;
   int start_cnt = 0;
   logic stub_mode = 1'b0;
   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   mult_dispatch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_product (mul_product),
      .mul_ready   (mul_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .busy        (busy),
      .timeout_err (timeout_err),
      .done_count  (done_count)
   );

   // Multiplier model: latches operands on mul_start, answers three edges later
   // with a one-cycle mul_ready; in stub mode it never answers.
   logic       m_busy;
   logic [1:0] m_cnt;
   logic [7:0] m_a;
   logic [7:0] m_b;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_cnt <= '0; m_a <= '0; m_b <= '0;
         mul_ready <= 1'b0; mul_product <= '0;
      end else if (mul_start) begin
         m_busy <= 1'b1; m_cnt <= 2'd3; m_a <= mul_a; m_b <= mul_b;
         mul_ready <= 1'b0;
      end else if (m_busy && m_cnt == 2'd1) begin
         m_busy <= 1'b0;
         mul_ready <= !stub_mode;
         mul_product <= 16'(m_a) * 16'(m_b);
      end else begin
         if (m_busy) m_cnt <= m_cnt - 2'd1;
         mul_ready <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) got_q.push_back(out_product);
      if (rst_n && mul_start) start_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      got_q.delete();
      exp_q.delete();
      start_cnt = 0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
      int tmo = 0;
      in_valid = 1'b1; in_a = a; in_b = b;
      while (!in_ready && tmo < 500) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 500) check("push_timeout", 32'(tmo), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_results(input int n, input string tag);
      int tmo = 0;
      while (got_q.size() < n && tmo < 4000) begin
         @(negedge clk);
         tmo++;
      end
      check(tag, 32'(got_q.size()), 32'(n));
   endtask

   task automatic wait_start();
      int tmo = 0;
      while (!mul_start && tmo < 200) begin
         @(negedge clk);
         tmo++;
      end
      check("wait_start", 32'(mul_start), 32'd1);
   endtask

   initial begin
      logic seen_ov;

      // Reset state
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_outs", {mul_start, out_valid, timeout_err, mul_a, mul_b}, 32'd0);
      check("rst_prod_cnt", {out_product, done_count}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single op with latency check
      @(negedge clk);
      push_pair(8'h0C, 8'h0A);
      check("lat_no_start_early", 32'(mul_start), 32'd0);
      @(negedge clk);
      check("lat_start", 32'(mul_start), 32'd1);
      check("lat_ops", {mul_a, mul_b}, 32'h0C0A);
      @(negedge clk);
      check("start_one_cycle", 32'(mul_start), 32'd0);
      wait_results(1, "single_cnt");
      check("single_prod", 32'(got_q[0]), 32'h0078);
      check("single_starts", 32'(start_cnt), 32'd1);
      check("single_done", 32'(done_count), 32'd1);

      // Burst of six
      do_reset();
      out_ready = 1'b1;
      exp_q = '{16'h000F, 16'h0100, 16'h00FE, 16'h88EF, 16'h00FF, 16'h4000};
      push_pair(8'h03, 8'h05);
      push_pair(8'h10, 8'h10);
      push_pair(8'h7F, 8'h02);
      push_pair(8'hAB, 8'hCD);
      push_pair(8'h01, 8'hFF);
      check("burst_full", 32'(in_ready), 32'd0);
      push_pair(8'h80, 8'h80);
      wait_results(6, "burst_cnt");
      for (int i = 0; i < 6; i++) check($sformatf("burst_prod%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      check("burst_done", 32'(done_count), 32'd6);

      // Backpressure
      do_reset();
      out_ready = 1'b0;
      push_pair(8'h12, 8'h34);
      push_pair(8'h05, 8'h07);
      begin
         int tmo = 0;
         while (!out_valid && tmo < 200) begin
            @(negedge clk);
            tmo++;
         end
      end
      for (int i = 0; i < 20; i++) begin
         check("bp_hold", {15'd0, out_valid, out_product}, 32'h0001_03A8);
         @(negedge clk);
      end
      check("bp_no_start", 32'(start_cnt), 32'd1);
      out_ready = 1'b1;
      wait_results(2, "bp_cnt");
      check("bp_first", 32'(got_q[0]), 32'h03A8);
      check("bp_second", 32'(got_q[1]), 32'h0023);
      check("bp_restart", 32'(start_cnt), 32'd2);

      // Edge operands and done_count wrap
      do_reset();
      push_pair(8'hFF, 8'hFF);
      push_pair(8'h00, 8'h37);
      wait_results(2, "edge_cnt");
      check("edge_ffxff", 32'(got_q[0]), 32'hFE01);
      check("edge_zero", 32'(got_q[1]), 32'h0000);
      for (int i = 0; i < 253; i++) push_pair(8'(i), 8'h03);
      wait_results(255, "wrap_cnt255");
      check("done_255", 32'(done_count), 32'd255);
      push_pair(8'h02, 8'h03);
      wait_results(256, "wrap_cnt256");
      check("done_wrap", 32'(done_count), 32'd0);
      check("wrap_last_prod", 32'(got_q[255]), 32'h0006);

      // Timeout with stub multiplier
      do_reset();
      stub_mode = 1'b1;
      push_pair(8'h0C, 8'h0A);
      wait_start();
      repeat (15) @(negedge clk);
      check("tmo_not_yet", 32'(timeout_err), 32'd0);
      @(negedge clk);
      check("tmo_set", 32'(timeout_err), 32'd1);
      check("tmo_idle", {busy, out_valid}, 32'd0);
      stub_mode = 1'b0;
      push_pair(8'h06, 8'h07);
      wait_results(1, "tmo_next_cnt");
      check("tmo_next_prod", 32'(got_q[0]), 32'h002A);
      check("tmo_sticky", 32'(timeout_err), 32'd1);
      check("tmo_done", 32'(done_count), 32'd1);

      // Reset in the middle of WAIT
      do_reset();
      push_pair(8'h02, 8'h03);
      wait_results(1, "mid_pre_cnt");
      push_pair(8'h04, 8'h05);
      push_pair(8'h06, 8'h07);
      wait_start();
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_ctl", {mul_start, out_valid, timeout_err, busy}, 32'd0);
      check("mid_ops", {mul_a, mul_b}, 32'd0);
      check("mid_prod_cnt", {out_product, done_count}, 32'd0);
      check("mid_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      got_q.delete();
      start_cnt = 0;
      seen_ov = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) seen_ov = 1'b1;
      end
      check("mid_no_out", {31'd0, seen_ov}, 32'd0);
      check("mid_no_result", 32'(got_q.size()), 32'd0);
      check("mid_no_start", 32'(start_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_dispatch.md
MULT_DISPATCH -- requirements
Module: mult_dispatch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, the operand FIFO entry count (power of two).
REQ-003 The block SHALL have parameter TIMEOUT, default 15, the maximum number of WAIT cycles before abort.
REQ-004 The block SHALL have these ports: clk  in  1  clock, rising edge; single clock domain.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  operand pair offered; in_ready  out  1  pair accepted when both are high.
REQ-007 in_a, in_b  in  WIDTH  operand pair.
REQ-008 mul_start  out  1  one-cycle start pulse to the sequential multiplier; mul_a, mul_b  out  WIDTH  operands to the multiplier.
REQ-009 mul_product  in  2*WIDTH  multiplier result; mul_ready  in  1  multiplier result valid.
REQ-010 out_valid  out  1; out_ready  in  1; out_product  out  2*WIDTH  result stream.
REQ-011 busy  out  1; timeout_err  out  1  sticky; done_count  out  8  count of completed results.

Function
REQ-012 The block SHALL buffer accepted pairs in a DEPTH-entry in-order FIFO, with in_ready = not full, independent of same-cycle pop.
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT and HOLD.
REQ-014 IDLE: if the FIFO is non-empty, the FSM SHALL pop the head into the mul_a/mul_b registers and enter ISSUE at the next edge.
REQ-015 ISSUE: mul_start SHALL be high for exactly this one cycle, with mul_a/mul_b stable; the FSM SHALL then enter WAIT.
REQ-016 WAIT: mul_ready SHALL be ignored in the first WAIT cycle; thereafter mul_ready=1 SHALL capture mul_product into out_product, set out_valid and enter HOLD.
REQ-017 WAIT: if TIMEOUT WAIT cycles elapse without capture, the block SHALL set timeout_err, discard the pair, leave out_valid low and enter IDLE.
REQ-018 HOLD: out_valid and out_product SHALL remain stable until out_ready=1; on that cycle the block SHALL clear out_valid, increment done_count (255 wraps to 0) and enter IDLE.
REQ-019 No mul_start SHALL occur outside ISSUE, so at most one multiplication is in flight.
REQ-020 mul_a and mul_b SHALL hold the last issued values outside ISSUE.
REQ-021 Latency: a pair pushed at edge t0 into an empty, IDLE block SHALL produce mul_start high in the cycle following edge t0+1.
REQ-022 Results SHALL leave in acceptance order, and the product SHALL be the unsigned product of the operands, full 2*WIDTH bits, with no truncation.
REQ-023 busy SHALL be high whenever state is not IDLE or the FIFO is non-empty.
REQ-024 timeout_err SHALL be cleared only by reset.

Reset
REQ-025 rst_n low SHALL asynchronously force state to IDLE and empty the FIFO.
REQ-026 rst_n low SHALL asynchronously zero mul_start, mul_a, mul_b, out_valid, out_product, timeout_err and done_count.
REQ-027 During reset in_ready SHALL be 1, since the FIFO is not full.
REQ-028 Reset asserted mid-WAIT or mid-HOLD SHALL abandon the operation, and no result SHALL be emitted after release.
REQ-029 Deassertion SHALL be synchronous in effect: the first possible push is at the first rising edge after release.

Structure
REQ-030 The state encoding, WIDTH default and TIMEOUT default SHALL be defined in shared package mult_pkg, which is shared with the multiplier.
REQ-031 The FIFO SHALL be a separate sub-module op_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, din, dout).
REQ-032 The FSM, timeout counter and done_count SHALL reside in mult_dispatch.

Verification
REQ-033 The bench SHALL attach a real multiplier2 instance for scenarios 034-037 and a stub for 038.
REQ-034 Single op: 0x0C, 0x0A -> out_product 0x0078, one mul_start pulse, done_count=1.
REQ-035 Burst: 6 back-to-back pairs with out_ready=1 -> in_ready low while 4 entries are held; 6 in-order correct products; done_count=6.
REQ-036 Backpressure: out_ready=0 for 20 cycles after out_valid -> out_product stable, no new mul_start; release -> next op issues.
REQ-037 Edges: 0xFF x 0xFF -> 0xFE01; 0x00 x 0x37 -> 0x0000; 256 completions -> done_count wraps to 0.
REQ-038 Timeout: stub holds mul_ready=0 -> timeout_err=1 after 15 WAIT cycles, FSM returns to IDLE, and the next pair completes normally with timeout_err still 1.
REQ-039 Reset mid-WAIT: rst_n pulsed low -> all outputs zero immediately, FIFO empty, and no out_valid after release.
